// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_ctrl
// Brief    : SPI master sequencer. It takes one host read/write request
//            (7-bit address, rw flag, write byte) and frames it on cs/sclk/mosi:
//            8 command bits {addr, rw}, then 8 data bits, then a cs-high guard
//            gap. The block returns read data together with a one-cycle done
//            pulse.
// Options  : SPI_MISO_SYNC_EN - passes miso through a 2-flop synchronizer and
//            delays the capture strobe to match (needs CLK_DIV >= 3).
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  localparam logic [7:0] C_HC_LAST  = 8'(CLK_DIV - 1);
  // The gap state runs one cycle past CS_GAP so done lands on the far side of
  // the guard interval.
  localparam logic [7:0] C_GAP_LAST = 8'(CS_GAP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_hc;
  logic [3:0]  r_bc;
  logic        r_high;
  logic [14:0] r_sr;
  logic        r_rw;
  logic [7:0]  r_rx;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_done;
  logic [7:0]  r_rdata;

  logic w_accept;
  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_sample;
  logic w_done_set;
  logic w_cap_en;
  logic w_cap_bit;

  assign w_accept = req && (r_state == S_IDLE);
  assign w_tick   = (r_state == S_GAP) ? (r_hc == C_GAP_LAST) : (r_hc == C_HC_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and sclk edge strobes
  always_comb begin
    w_next     = r_state;
    w_rise     = 1'b0;
    w_fall     = 1'b0;
    w_sample   = 1'b0;
    w_done_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SETUP;
      end
      S_SETUP: begin
        if (w_tick) begin
          w_next = S_SHIFT;
          w_rise = 1'b1;
        end
      end
      S_SHIFT: begin
        if (w_tick) begin
          if (r_high) begin
            w_fall = 1'b1;
          end else if (r_bc == 4'd15) begin
            w_next = S_HOLD;
          end else begin
            // A rise out of bits 7..14 starts data bits 8..15.
            w_rise   = 1'b1;
            w_sample = (r_bc >= 4'd7);
          end
        end
      end
      S_HOLD: begin
        if (w_tick) w_next = S_GAP;
      end
      S_GAP: begin
        if (w_tick) begin
          w_next     = S_IDLE;
          w_done_set = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Half-period counter; it restarts on every tick and on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                                r_hc <= 8'd0;
    else if (r_state == S_IDLE || w_tick || w_next != r_state) r_hc <= 8'd0;
    else                                                      r_hc <= r_hc + 8'd1;
  end

  // Serial datapath: request capture, sclk and mosi generation, bit position
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sr   <= 15'd0;
      r_rw   <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_bc   <= 4'd0;
      r_high <= 1'b0;
    end else begin
      if (w_accept) begin
        // Bit 15 goes straight to mosi. The rest wait in r_sr. Reads send
        // zeros in the data phase.
        r_sr   <= {addr[5:0], rw, (rw ? 8'h00 : wdata)};
        r_mosi <= addr[6];
        r_rw   <= rw;
      end
      if (w_rise) begin
        r_sclk <= 1'b1;
        r_high <= 1'b1;
        r_bc   <= (r_state == S_SHIFT) ? (r_bc + 4'd1) : 4'd0;
      end
      if (w_fall) begin
        r_sclk <= 1'b0;
        r_high <= 1'b0;
        r_mosi <= r_sr[14];
        r_sr   <= {r_sr[13:0], 1'b0};
      end
    end
  end

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] r_sync;
  logic [1:0] r_cap;

  // Two-flop miso synchronizer with the capture strobe delayed to match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_cap  <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], miso};
      r_cap  <= {r_cap[0], w_sample};
    end
  end

  assign w_cap_en  = r_cap[1];
  assign w_cap_bit = r_sync[1];
`else
  assign w_cap_en  = w_sample;
  assign w_cap_bit = miso;
`endif

  // Receive shift register, MSB first
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_rx <= 8'h00;
    else if (w_cap_en) r_rx <= {r_rx[6:0], w_cap_bit};
  end

  // Completion pulse and read-data hand-off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done  <= 1'b0;
      r_rdata <= 8'h00;
    end else begin
      r_done <= w_done_set;
      if (w_done_set && r_rw) r_rdata <= r_rx;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign cs    = !((r_state == S_SETUP) || (r_state == S_SHIFT) || (r_state == S_HOLD));
  assign sclk  = r_sclk;
  assign mosi  = r_mosi;
  assign done  = r_done;
  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_ctrl
// Brief    : Bench for spi_master_ctrl. It runs a default-parameter instance
//            and a CLK_DIV=2 / CS_GAP=1 instance. A slave model answers
//            reads, and expected frames, rdata and timing are derived from the
//            transaction itself.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_ctrl;

  localparam int D_A = 4;
  localparam int G_A = 4;
  localparam int D_B = 2;
  localparam int G_B = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       req   [2];
  logic       rw    [2];
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic       ready [2];
  logic       done  [2];
  logic [7:0] rdata [2];
  logic       cs    [2];
  logic       sclk  [2];
  logic       mosi  [2];
  logic       miso  [2] = '{default: 1'b0};

  // slave-side observation and reference state
  logic [15:0] mosi_word [2];
  int          rises     [2];
  int          falls     [2];
  int          fbase     [2];
  logic [7:0]  sbyte     [2];
  logic [7:0]  mdl_rd    [2];
  time         t_prev    [2];
  time         t_last    [2];

  int n_checks = 0;
  int n_pass   = 0;

  spi_master_ctrl #(.CLK_DIV(D_A), .CS_GAP(G_A)) u_dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .ready(ready[0]), .done(done[0]), .rdata(rdata[0]),
    .cs(cs[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master_ctrl #(.CLK_DIV(D_B), .CS_GAP(G_B)) u_dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .ready(ready[1]), .done(done[1]), .rdata(rdata[1]),
    .cs(cs[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Slave model: record mosi at each rise; drive the read byte after falls 8..15
  for (genvar g = 0; g < 2; g++) begin : g_slave
    always @(posedge sclk[g]) begin
      mosi_word[g] = {mosi_word[g][14:0], mosi[g]};
      rises[g]     = rises[g] + 1;
      t_prev[g]    = t_last[g];
      t_last[g]    = $time;
    end
    always @(negedge sclk[g]) begin
      falls[g] = falls[g] + 1;
      if ((falls[g] - fbase[g]) >= 8 && (falls[g] - fbase[g]) <= 15)
        miso[g] = sbyte[g][15 - (falls[g] - fbase[g])];
      else
        miso[g] = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One full transaction with reference-model expectations. When noisy is
  // set, req toggles randomly while the block is busy.
  task automatic xfer(input int s, input logic rw_i, input logic [6:0] ad,
                      input logic [7:0] wd, input logic [7:0] sb, input bit noisy);
    int         dv;
    int         gv;
    int         lat;
    int         cslow;
    int         r0;
    logic [7:0] exp_rd;
    dv = (s == 0) ? D_A : D_B;
    gv = (s == 0) ? G_A : G_B;
    for (int i = 0; i < 400 && !ready[s]; i++) @(negedge clk);
    @(negedge clk);
    check("ready_before_req", 32'(ready[s]), 32'd1);
    sbyte[s] = sb;
    fbase[s] = falls[s];
    r0       = rises[s];
    rw[s] = rw_i; addr[s] = ad; wdata[s] = wd; req[s] = 1'b1;
    @(posedge clk); #1;
    req[s] = 1'b0;
    check("ready_drops", 32'(ready[s]), 32'd0);
    lat = 0; cslow = 0;
    while (lat < 3000 && !done[s]) begin
      if (!cs[s]) cslow++;
      if (noisy) req[s] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    req[s] = 1'b0;
    exp_rd    = rw_i ? sb : mdl_rd[s];
    mdl_rd[s] = exp_rd;
    check("done_latency", 32'(lat), 32'(1 + 34 * dv + gv));
    check("cs_low_cycles", 32'(cslow), 32'(34 * dv));
    check("sclk_rises", 32'(rises[s] - r0), 32'd16);
    check("mosi_frame", 32'(mosi_word[s]), 32'({ad, rw_i, (rw_i ? 8'h00 : wd)}));
    check("rdata", 32'(rdata[s]), 32'(exp_rd));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done[s]), 32'd0);
    check("ready_after_done", 32'(ready[s]), 32'd1);
  endtask

  initial begin
    int phase;
    int gap;
    int nd;
    for (int s = 0; s < 2; s++) begin
      req[s] = 1'b0; rw[s] = 1'b0; addr[s] = 7'd0; wdata[s] = 8'd0;
      sbyte[s] = 8'd0; fbase[s] = 0; mdl_rd[s] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", 32'(cs[0]), 32'd1);
    check("rst_sclk", 32'(sclk[0]), 32'd0);
    check("rst_mosi", 32'(mosi[0]), 32'd0);
    check("rst_done", 32'(done[0]), 32'd0);
    check("rst_ready", 32'(ready[0]), 32'd1);
    check("rst_rdata", 32'(rdata[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // directed write and read
    xfer(0, 1'b0, 7'h15, 8'hA5, 8'h00, 1'b0);
    xfer(0, 1'b1, 7'h7F, 8'h00, 8'h3C, 1'b0);

    // reset in the middle of a read (rdata currently holds 3C)
    @(negedge clk);
    rw[0] = 1'b1; addr[0] = 7'h33; sbyte[0] = 8'hFF; fbase[0] = falls[0]; req[0] = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_cs", 32'(cs[0]), 32'd1);
    check("midrst_sclk", 32'(sclk[0]), 32'd0);
    check("midrst_mosi", 32'(mosi[0]), 32'd0);
    check("midrst_rdata", 32'(rdata[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mdl_rd[0] = 8'h00; mdl_rd[1] = 8'h00;
    #1;
    check("midrst_ready", 32'(ready[0]), 32'd1);
    nd = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (done[0]) nd++;
    end
    check("midrst_no_done", 32'(nd), 32'd0);

    // back-to-back: req held high across done
    @(negedge clk);
    rw[0] = 1'b0; addr[0] = 7'h2A; wdata[0] = 8'h5C; req[0] = 1'b1;
    phase = 0; gap = 0;
    for (int i = 0; i < 1000 && phase < 3; i++) begin
      @(posedge clk); #1;
      case (phase)
        0: if (!cs[0]) phase = 1;
        1: if (cs[0]) begin phase = 2; gap = 0; end
        2: begin gap++; if (!cs[0]) phase = 3; end
        default: ;
      endcase
    end
    req[0] = 1'b0;
    check("b2b_cs_high_cycles", 32'(gap), 32'(G_A + 2));
    for (int i = 0; i < 400 && !done[0]; i++) begin
      @(posedge clk); #1;
    end

    // randomized traffic with req noise while busy
    for (int n = 0; n < 16; n++)
      xfer(0, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    // fastest divider / shortest gap instance
    xfer(1, 1'b1, 7'h41, 8'h00, 8'h81, 1'b0);
    check("b_sclk_period_clks", 32'((t_last[1] - t_prev[1]) / 10), 32'd4);
    for (int n = 0; n < 6; n++)
      xfer(1, 1'($urandom_range(0, 1)), 7'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master sequencer that drives the SPI memory slave (cs/sclk/mosi/miso) on behalf of a parallel host.
- Host issues one read or write request: 7-bit address, rw flag and write byte.
- Block frames the transfer: cs low, 8 address/command bits, 8 data bits, cs high, then a guard gap.
- It then returns read data with a one-cycle done pulse. Sits between host logic and the SPI memory pins.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; legal range 2..255.
- CS_GAP, 4, clk cycles cs held high after a transfer before done/ready; legal range 1..255.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-high reset
- req  input  1  host request, sampled only while ready=1
- rw  input  1  1=read, 0=write; captured with req
- addr  input  7  memory address; captured with req
- wdata  input  8  write byte; captured with req
- ready  output  1  high in IDLE; request accepted on clk edge with req&&ready
- done  output  1  one-cycle pulse at end of transaction
- rdata  output  8  read byte; valid from done, held until next read's done
- cs  output  1  chip select to slave, 1=idle/deselected
- sclk  output  1  serial clock, idles 0
- mosi  output  1  serial data to slave
- miso  input  1  serial data from slave

Behaviour:
- Reset (async): state=IDLE, cs=1, sclk=0, mosi=0, done=0, ready=1, rdata=8'h00, all counters 0.
- Accept: on the edge with req&&ready, latch shift word {addr[6:0], rw} then wdata (16 bits, MSB first); ready drops next cycle. req while busy is ignored; no queueing.
- Half-period counter hc counts 0..CLK_DIV-1; tick when hc==CLK_DIV-1; hc clears on tick and on state entry.
- States:
  - IDLE -> SETUP on accept.
  - SETUP: 1 half-period; cs=0, sclk=0, mosi=bit15. On tick -> SHIFT.
  - SHIFT: 16 bits, bit counter 0..15. Each bit has a high half then a low half.
    - Tick ending a low half (or SETUP): sclk rises.
    - Tick ending a high half: sclk falls, and mosi advances to the next bit.
  - SHIFT on read (rw=1):
    - Bits 8..15 (data phase): mosi=0.
    - miso is sampled into rx shift register on each clk edge where sclk goes 0->1 during bits 8..15, MSB first.
  - SHIFT on write: bits 8..15 carry wdata.
  - After the falling edge of bit 15 -> HOLD.
  - HOLD: 1 half-period, cs=0, sclk=0. On tick -> GAP with cs=1.
  - GAP: CS_GAP cycles with cs=1. On last cycle: done=1 for one cycle, rdata<=rx (read only; writes leave rdata unchanged), state -> IDLE, ready=1 next cycle.
- Latency: done asserts exactly 1 + 34*CLK_DIV + CS_GAP cycles after the accept edge (141 at defaults).
- sclk rising edges per transaction: exactly 16; cs low for exactly 34*CLK_DIV cycles.
- Reset mid-transfer: cs returns to 1 and sclk to 0 immediately (asynchronously); no done pulse; rdata cleared.
- mosi changes only while sclk=0, or on the same edge sclk falls; never on a rising edge.

Optional Feature:
- Macro: SPI_MISO_SYNC_EN.
- Defined: miso passes through a 2-flop synchronizer (reset 0); capture point moves 2 clk cycles after each sclk rise; requires CLK_DIV>=3; latency unchanged.
- Undefined: miso sampled directly on the sclk rising edge as above.

Test Plan:
- Reset asserted mid-SHIFT -> cs=1, sclk=0, mosi=0 within same cycle, ready=1 after release, no done.
- Write addr=7'h15, wdata=8'hA5 -> mosi bits at 16 sclk rises = 0010101_0 then 10100101; done at cycle 141; rdata unchanged.
- Read addr=7'h7F, slave model drives 8'h3C on falling edges -> command byte 11111111, mosi=0 in data phase, rdata=8'h3C at done.
- req pulsed repeatedly while busy -> exactly one transaction (16 sclk rises), second request accepted only after ready returns.
- Back-to-back: req held high across done -> next cs fall exactly CS_GAP+2 cycles after the previous cs rise; cs high >= CS_GAP cycles.
- CLK_DIV=2, CS_GAP=1 -> done at cycle 70; sclk period 4 clk; read of 8'h81 returns 8'h81.
